// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the BRAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_arb_pkg;

  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_ADDR_WIDTH   = 9;
  localparam int DEF_TID_WIDTH    = 9;
  localparam int DEF_BRAM_LATENCY = 1;
  localparam int DEF_CNT_WIDTH    = 32;

  // Tag field inside the tracking entry is sized for the widest tid we expect.
  localparam int TRK_TID_WIDTH    = 16;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_ENG  = 1'b1
  } t_rd_owner;

  typedef struct packed {
    logic                     valid;
    t_rd_owner                owner;
    logic [TRK_TID_WIDTH-1:0] tid;
  } t_rd_track;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Host MMIO and AFU engine request/response bundle for the BRAM port arbiter.
// Latency: n/a (wiring only).
// Backpressure: host side has none; engine requests use valid/ready.
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int TID_WIDTH  = 9
);
  logic                  host_wr_en;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DATA_WIDTH-1:0] host_wr_data;
  logic                  host_rd_en;
  logic [ADDR_WIDTH-1:0] host_rd_addr;
  logic [TID_WIDTH-1:0]  host_rd_tid;
  logic                  host_rsp_valid;
  logic [TID_WIDTH-1:0]  host_rsp_tid;
  logic [DATA_WIDTH-1:0] host_rsp_data;

  logic                  eng_wr_valid;
  logic                  eng_wr_ready;
  logic [ADDR_WIDTH-1:0] eng_wr_addr;
  logic [DATA_WIDTH-1:0] eng_wr_data;
  logic                  eng_rd_valid;
  logic                  eng_rd_ready;
  logic [ADDR_WIDTH-1:0] eng_rd_addr;
  logic                  eng_rsp_valid;
  logic [DATA_WIDTH-1:0] eng_rsp_data;

  // Requesters (MMIO decode + engine) drive requests and consume responses.
  modport master (
    output host_wr_en, host_wr_addr, host_wr_data,
    output host_rd_en, host_rd_addr, host_rd_tid,
    input  host_rsp_valid, host_rsp_tid, host_rsp_data,
    output eng_wr_valid, eng_wr_addr, eng_wr_data,
    input  eng_wr_ready,
    output eng_rd_valid, eng_rd_addr,
    input  eng_rd_ready,
    input  eng_rsp_valid, eng_rsp_data
  );

  // The arbiter consumes requests and produces readies and responses.
  modport slave (
    input  host_wr_en, host_wr_addr, host_wr_data,
    input  host_rd_en, host_rd_addr, host_rd_tid,
    output host_rsp_valid, host_rsp_tid, host_rsp_data,
    input  eng_wr_valid, eng_wr_addr, eng_wr_data,
    output eng_wr_ready,
    input  eng_rd_valid, eng_rd_addr,
    output eng_rd_ready,
    output eng_rsp_valid, eng_rsp_data
  );
endinterface

// File: rtl/bram_port_arbiter_rd_track_pipe.sv
// Shift register of read-tracking tags aligned with the BRAM read data.
// Latency: DEPTH cycles from in_entry to tail.
// Backpressure: none; advances every cycle.
module rd_track_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  t_rd_track in_entry,
  output t_rd_track tail
);

  t_rd_track pipe_q [DEPTH];
  t_rd_track pipe_d [DEPTH];

  // Shift one stage per cycle, new entry enters at stage 0
  always_comb begin
    pipe_d[0] = in_entry;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle later.
// Backpressure: none.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the BRAM write/read ports between host MMIO (strict priority) and the AFU engine.
// Latency: read response 1+BRAM_LATENCY cycles after grant; write hits BRAM 1 cycle after grant.
// Backpressure: host never stalled; engine ready drops while the host holds the same port.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int TID_WIDTH    = DEF_TID_WIDTH,
  parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_arbiter_if.slave    bus,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic [CNT_WIDTH-1:0]  stat_host_rd,
  output logic [CNT_WIDTH-1:0]  stat_eng_rd,
  output logic [CNT_WIDTH-1:0]  stat_eng_stall
);

  localparam int PIPE_DEPTH = 1 + BRAM_LATENCY;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  t_rd_track             trk_in, trk_tail;
  logic                  host_rd_gnt, eng_rd_gnt, eng_stall;

  assign bus.eng_wr_ready = !bus.host_wr_en;
  assign bus.eng_rd_ready = !bus.host_rd_en;
  assign eng_stall = (bus.eng_rd_valid && bus.host_rd_en) ||
                     (bus.eng_wr_valid && bus.host_wr_en);

  // Host-first grant on each port; the winner's request is staged for the BRAM
  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    trk_in      = '0;
    host_rd_gnt = bus.host_rd_en;
    eng_rd_gnt  = bus.eng_rd_valid && !bus.host_rd_en;

    if (bus.host_wr_en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.host_wr_addr;
      wr_data_d = bus.host_wr_data;
    end else if (bus.eng_wr_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.eng_wr_addr;
      wr_data_d = bus.eng_wr_data;
    end

    if (host_rd_gnt) begin
      rd_addr_d    = bus.host_rd_addr;
      trk_in.valid = 1'b1;
      trk_in.owner = OWNER_HOST;
      trk_in.tid   = TRK_TID_WIDTH'(bus.host_rd_tid);
    end else if (eng_rd_gnt) begin
      rd_addr_d    = bus.eng_rd_addr;
      trk_in.valid = 1'b1;
      trk_in.owner = OWNER_ENG;
    end
  end

  // Issue-stage registers feeding the BRAM ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign bram_rd_addr = rd_addr_q;

  rd_track_pipe #(.DEPTH(PIPE_DEPTH)) u_rd_track (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_entry (trk_in),
    .tail     (trk_tail)
  );

  // Steer returning data to its owner; idle ports show zero
  always_comb begin
    bus.host_rsp_valid = 1'b0;
    bus.host_rsp_tid   = '0;
    bus.host_rsp_data  = '0;
    bus.eng_rsp_valid  = 1'b0;
    bus.eng_rsp_data   = '0;
    if (trk_tail.valid) begin
      if (trk_tail.owner == OWNER_HOST) begin
        bus.host_rsp_valid = 1'b1;
        bus.host_rsp_tid   = TID_WIDTH'(trk_tail.tid);
        bus.host_rsp_data  = bram_rd_data;
      end else begin
        bus.eng_rsp_valid  = 1'b1;
        bus.eng_rsp_data   = bram_rd_data;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_host_rd (
    .clk(clk), .rst_n(rst_n), .inc(host_rd_gnt), .cnt(stat_host_rd)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_eng_rd (
    .clk(clk), .rst_n(rst_n), .inc(eng_rd_gnt), .cnt(stat_eng_rd)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_eng_stall (
    .clk(clk), .rst_n(rst_n), .inc(eng_stall), .cnt(stat_eng_stall)
  );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus constrained-random traffic.
// A read-first BRAM model sits on the bram_* ports; a reference memory predicts responses.
// Engine requests are held stable until accepted.
module tb_bram_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int TW = 9;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW)) bus ();

  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_wr_data;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic [CW-1:0] stat_host_rd, stat_eng_rd, stat_eng_stall;

  bram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW), .BRAM_LATENCY(1), .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .bram_wr_en     (bram_wr_en),
    .bram_wr_addr   (bram_wr_addr),
    .bram_wr_data   (bram_wr_data),
    .bram_rd_addr   (bram_rd_addr),
    .bram_rd_data   (bram_rd_data),
    .stat_host_rd   (stat_host_rd),
    .stat_eng_rd    (stat_eng_rd),
    .stat_eng_stall (stat_eng_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input int i);
    if (i == 5)      return 64'hDEAD_BEEF;
    else if (i == 2) return 64'h11;
    else             return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  // BRAM model: one-cycle registered read, read-first on collision
  logic [DW-1:0] mem [512];
  bit mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (bram_wr_en) begin
      mem[bram_wr_addr] <= bram_wr_data;
    end
    bram_rd_data <= mem[bram_rd_addr];
  end

  // Reference model: expected response per edge index, kept in a small ring
  typedef struct {
    bit            v;
    bit            host;
    logic [TW-1:0] tid;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          slot [8];
  logic [DW-1:0] ref_mem [512];
  bit            ref_init;
  int unsigned   edge_cnt = 0;
  int unsigned   m_host_rd, m_eng_rd, m_stall;
  bit            m_wr_en;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic [DW-1:0] m_wr_data;

  always @(posedge clk) begin : model
    int unsigned n;
    if (!ref_init) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    n = (edge_cnt + 1) & 7;
    slot[n] = '{v: 1'b0, host: 1'b0, tid: '0, dat: '0};
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) slot[i] = '{v: 1'b0, host: 1'b0, tid: '0, dat: '0};
      m_host_rd = 0; m_eng_rd = 0; m_stall = 0;
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
    end else begin
      // Reads see memory as it stood before this cycle's write
      if (bus.host_rd_en) begin
        slot[n] = '{v: 1'b1, host: 1'b1, tid: bus.host_rd_tid, dat: ref_mem[bus.host_rd_addr]};
        m_rd_addr = bus.host_rd_addr;
        m_host_rd++;
      end else if (bus.eng_rd_valid) begin
        slot[n] = '{v: 1'b1, host: 1'b0, tid: '0, dat: ref_mem[bus.eng_rd_addr]};
        m_rd_addr = bus.eng_rd_addr;
        m_eng_rd++;
      end
      if ((bus.eng_rd_valid && bus.host_rd_en) || (bus.eng_wr_valid && bus.host_wr_en))
        m_stall++;
      m_wr_en = 1'b0;
      if (bus.host_wr_en) begin
        m_wr_en = 1'b1; m_wr_addr = bus.host_wr_addr; m_wr_data = bus.host_wr_data;
        ref_mem[bus.host_wr_addr] = bus.host_wr_data;
      end else if (bus.eng_wr_valid) begin
        m_wr_en = 1'b1; m_wr_addr = bus.eng_wr_addr; m_wr_data = bus.eng_wr_data;
        ref_mem[bus.eng_wr_addr] = bus.eng_wr_data;
      end
    end
    edge_cnt = edge_cnt + 1;
  end

  // Compare every cycle, mid-period
  exp_t cs;
  int   host_seen = 0;
  int   eng_seen  = 0;
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      cs = slot[(edge_cnt - 1) & 7];
      chk("host_rsp_valid", bus.host_rsp_valid, cs.v && cs.host);
      chk("eng_rsp_valid", bus.eng_rsp_valid, cs.v && !cs.host);
      if (cs.v && cs.host) begin
        chk("host_rsp_tid", bus.host_rsp_tid, cs.tid);
        chk("host_rsp_data", bus.host_rsp_data, cs.dat);
      end
      if (cs.v && !cs.host) chk("eng_rsp_data", bus.eng_rsp_data, cs.dat);
      chk("rsp_exclusive", bus.host_rsp_valid && bus.eng_rsp_valid, 1'b0);
      chk("eng_wr_ready", bus.eng_wr_ready, !bus.host_wr_en);
      chk("eng_rd_ready", bus.eng_rd_ready, !bus.host_rd_en);
      chk("stat_host_rd", stat_host_rd, m_host_rd);
      chk("stat_eng_rd", stat_eng_rd, m_eng_rd);
      chk("stat_eng_stall", stat_eng_stall, m_stall);
      chk("bram_wr_en", bram_wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("bram_wr_addr", bram_wr_addr, m_wr_addr);
        chk("bram_wr_data", bram_wr_data, m_wr_data);
      end
      chk("bram_rd_addr", bram_rd_addr, m_rd_addr);
      if (bus.host_rsp_valid) host_seen++;
      if (bus.eng_rsp_valid)  eng_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    bus.host_wr_en = 1'b0; bus.host_rd_en = 1'b0;
    bus.eng_wr_valid = 1'b0; bus.eng_rd_valid = 1'b0;
  endtask

  int h0, e0;
  bit wr_done, rd_done;

  initial begin
    bus.host_wr_addr = '0; bus.host_wr_data = '0;
    bus.host_rd_addr = '0; bus.host_rd_tid = '0;
    bus.eng_wr_addr = '0; bus.eng_wr_data = '0; bus.eng_rd_addr = '0;
    idle();
    repeat (3) tick();
    chk("reset_host_rsp_valid", bus.host_rsp_valid, 1'b0);
    chk("reset_bram_wr_en", bram_wr_en, 1'b0);
    chk("reset_stat_host_rd", stat_host_rd, 0);
    rst_n = 1'b1;
    tick();

    // Host read of a preloaded word, 2-cycle return
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 9'd5; bus.host_rd_tid = 9'h1A;
    tick();
    idle();
    chk("t1_not_early", bus.host_rsp_valid, 1'b0);
    tick();
    chk("t1_valid", bus.host_rsp_valid, 1'b1);
    chk("t1_tid", bus.host_rsp_tid, 9'h1A);
    chk("t1_data", bus.host_rsp_data, 64'hDEAD_BEEF);
    chk("t1_eng_quiet", bus.eng_rsp_valid, 1'b0);
    tick();
    chk("t1_single", bus.host_rsp_valid, 1'b0);

    // Host and engine read in the same cycle
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 9'd3; bus.host_rd_tid = 9'h33;
    bus.eng_rd_valid = 1'b1; bus.eng_rd_addr = 9'd4;
    #1 chk("t2_eng_rd_ready_low", bus.eng_rd_ready, 1'b0);
    tick();
    bus.host_rd_en = 1'b0;
    #1 chk("t2_eng_rd_ready_high", bus.eng_rd_ready, 1'b1);
    tick();
    bus.eng_rd_valid = 1'b0;
    chk("t2_host_data", bus.host_rsp_data, 64'hA5A5_0000_0000_0003);
    tick();
    chk("t2_eng_valid", bus.eng_rsp_valid, 1'b1);
    chk("t2_eng_data", bus.eng_rsp_data, 64'hA5A5_0000_0000_0004);
    chk("t2_stall_cnt", stat_eng_stall, 1);
    chk("t2_eng_rd_cnt", stat_eng_rd, 1);

    // Colliding writes: host lands first, engine next cycle
    bus.host_wr_en = 1'b1; bus.host_wr_addr = 9'd7; bus.host_wr_data = 64'hAAAA;
    bus.eng_wr_valid = 1'b1; bus.eng_wr_addr = 9'd7; bus.eng_wr_data = 64'h1234;
    tick();
    bus.host_wr_en = 1'b0;
    chk("t3_first_write", bram_wr_data, 64'hAAAA);
    tick();
    bus.eng_wr_valid = 1'b0;
    chk("t3_second_write", bram_wr_data, 64'h1234);
    tick();
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 9'd7; bus.host_rd_tid = 9'd7;
    tick();
    idle();
    tick();
    chk("t3_final_read", bus.host_rsp_data, 64'h1234);

    // Read-first on same-cycle read/write, new data one cycle later
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 9'd2; bus.host_rd_tid = 9'd2;
    bus.eng_wr_valid = 1'b1; bus.eng_wr_addr = 9'd2; bus.eng_wr_data = 64'h22;
    tick();
    bus.eng_wr_valid = 1'b0; bus.host_rd_tid = 9'd3;
    tick();
    bus.host_rd_en = 1'b0;
    chk("t4_old_data", bus.host_rsp_data, 64'h11);
    tick();
    chk("t4_new_data", bus.host_rsp_data, 64'h22);
    chk("t4_new_tid", bus.host_rsp_tid, 9'd3);

    // Alternating host/engine reads for 20 cycles
    h0 = host_seen; e0 = eng_seen;
    for (int i = 0; i < 20; i++) begin
      bus.host_rd_en = (i % 2 == 0);
      bus.host_rd_addr = AW'(i); bus.host_rd_tid = TW'(i + 100);
      bus.eng_rd_valid = (i % 2 == 1);
      bus.eng_rd_addr = AW'(i);
      tick();
    end
    idle();
    repeat (2) tick();
    chk("t5_host_count", host_seen - h0, 10);
    chk("t5_eng_count", eng_seen - e0, 10);

    // Reset with reads in flight
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 9'd1; bus.host_rd_tid = 9'd5;
    bus.eng_rd_valid = 1'b1; bus.eng_rd_addr = 9'd6;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("t6_host_valid", bus.host_rsp_valid, 1'b0);
    chk("t6_eng_valid", bus.eng_rsp_valid, 1'b0);
    chk("t6_stat_host", stat_host_rd, 0);
    chk("t6_stat_stall", stat_eng_stall, 0);
    chk("t6_rd_addr", bram_rd_addr, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_no_late_rsp", bus.host_rsp_valid || bus.eng_rsp_valid, 1'b0);

    // Random traffic on a narrow address range to force collisions
    for (int c = 0; c < 2000; c++) begin
      wr_done = bus.eng_wr_valid && !bus.host_wr_en;
      rd_done = bus.eng_rd_valid && !bus.host_rd_en;
      bus.host_wr_en = ($urandom_range(0, 2) == 0);
      bus.host_wr_addr = AW'($urandom_range(0, 15));
      bus.host_wr_data = {$urandom, $urandom};
      bus.host_rd_en = ($urandom_range(0, 2) == 0);
      bus.host_rd_addr = AW'($urandom_range(0, 15));
      bus.host_rd_tid = TW'($urandom);
      if (!bus.eng_wr_valid || wr_done) begin
        bus.eng_wr_valid = $urandom_range(0, 1) == 1;
        bus.eng_wr_addr = AW'($urandom_range(0, 15));
        bus.eng_wr_data = {$urandom, $urandom};
      end
      if (!bus.eng_rd_valid || rd_done) begin
        bus.eng_rd_valid = $urandom_range(0, 1) == 1;
        bus.eng_rd_addr = AW'($urandom_range(0, 15));
      end
      tick();
    end
    idle();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
